// File: rtl/env_detect_if.sv
// env_detect bus: sample stream and tracking controls in,
// envelope and gate out.
interface env_detect_if;
  logic              sample_valid;
  logic signed [7:0] sample;
  logic        [7:0] ai;
  logic        [7:0] ri;
  logic        [7:0] th_on;
  logic        [7:0] th_off;
  logic        [7:0] hold;
  logic        [7:0] envelope;
  logic              gate;
  logic              onset;

  modport master (
    output sample_valid, sample, ai, ri,
    output th_on, th_off, hold,
    input  envelope, gate, onset
  );

  modport slave (
    input  sample_valid, sample, ai, ri,
    input  th_on, th_off, hold,
    output envelope, gate, onset
  );
endinterface

// File: rtl/env_detect.sv
// Envelope follower with attack/release slew and a
// hysteretic note gate that holds off for a programmable time.
module env_detect (
  input logic         clk,
  input logic         rst,
  env_detect_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ON,
    HOLD
  } state_t;

  state_t     r_state;
  logic [7:0] r_env;
  logic [7:0] r_cnt;
  logic       r_gate;
  logic       r_onset;

  logic [7:0] w_abs;
  logic [7:0] w_mag;
  logic [8:0] w_sum;
  logic [8:0] w_diff;
  logic [7:0] w_next;

  // rectify, saturate to 127 and double so the range spans 0..254
  always_comb begin
    w_abs = bus.sample[7] ? (8'd0 - bus.sample) : bus.sample;
    w_mag = w_abs[7] ? 8'd254 : {w_abs[6:0], 1'b0};
  end

  // slew toward mag without overshoot or wrap
  always_comb begin
    w_sum  = {1'b0, r_env} + {1'b0, bus.ai};
    w_diff = {1'b0, r_env} - {1'b0, bus.ri};
    w_next = r_env;
    unique case (1'b1)
      (w_mag > r_env):
        w_next = (w_sum > {1'b0, w_mag}) ? w_mag : w_sum[7:0];
      (w_mag < r_env):
        w_next = (w_diff[8] || (w_diff[7:0] < w_mag))
                 ? w_mag : w_diff[7:0];
      default:
        w_next = r_env;
    endcase
  end

  // envelope register and gate FSM, judged on the incoming envelope
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_env   <= 8'd0;
      r_cnt   <= 8'd0;
      r_gate  <= 1'b0;
      r_onset <= 1'b0;
    end else begin
      r_onset <= 1'b0;
      if (bus.sample_valid) begin
        r_env <= w_next;
        unique case (r_state)
          IDLE: begin
            if (w_next >= bus.th_on) begin
              r_state <= ON;
              r_gate  <= 1'b1;
              r_onset <= 1'b1;
            end
          end
          ON: begin
            if (w_next < bus.th_off) begin
              if (bus.hold == 8'd0) begin
                r_state <= IDLE;
                r_gate  <= 1'b0;
              end else begin
                r_state <= HOLD;
                r_cnt   <= bus.hold;
              end
            end
          end
          HOLD: begin
            if (w_next >= bus.th_on) begin
              r_state <= ON;
            end else if (r_cnt == 8'd1) begin
              r_state <= IDLE;
              r_gate  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_gate  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.envelope = r_env;
  assign bus.gate     = r_gate;
  assign bus.onset    = r_onset;
endmodule

// File: tb/tb_env_detect.sv
// Directed bench for env_detect: reset, slew, magnitude,
// gate/hold, retrigger and valid-gap behaviour.
module tb_env_detect;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  env_detect_if bus ();

  env_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic v, input logic signed [7:0] s);
    @(negedge clk);
    bus.sample_valid = v;
    bus.sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic gate_setup(input logic [7:0] h);
    bus.ai     = 8'd255;
    bus.ri     = 8'd255;
    bus.th_on  = 8'd128;
    bus.th_off = 8'd64;
    bus.hold   = h;
  endtask

  task automatic test_reset();
    do_reset();
    gate_setup(8'd3);
    n_chk++;
    if (bus.envelope !== 8'd0 || bus.gate !== 1'b0
        || bus.onset !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init env=%0d gate=%b onset=%b want 0 0 0",
               bus.envelope, bus.gate, bus.onset);
    end
    step(1'b1, 8'sd100);
    n_chk++;
    if (bus.envelope !== 8'd200 || bus.onset !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre env=%0d onset=%b want 200 1",
               bus.envelope, bus.onset);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (bus.envelope !== 8'd0 || bus.gate !== 1'b0
        || bus.onset !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async env=%0d gate=%b onset=%b want 0 0 0",
               bus.envelope, bus.gate, bus.onset);
    end
    rst = 1'b0;
    step(1'b1, 8'sd100);
    n_chk++;
    if (bus.envelope !== 8'd200 || bus.gate !== 1'b1
        || bus.onset !== 1'b1) begin
      n_err++;
      $display("FAIL reset_restart env=%0d gate=%b onset=%b want 200 1 1",
               bus.envelope, bus.gate, bus.onset);
    end
  endtask

  task automatic test_attack();
    logic [7:0] exp;
    do_reset();
    bus.ai     = 8'd16;
    bus.ri     = 8'd4;
    bus.th_on  = 8'd255;
    bus.th_off = 8'd0;
    bus.hold   = 8'd0;
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 8'sd100);
      exp = (k <= 12) ? 8'(16 * k) : 8'd200;
      n_chk++;
      if (bus.envelope !== exp || bus.gate !== 1'b0) begin
        n_err++;
        $display("FAIL attack[%0d] env=%0d gate=%b want %0d 0",
                 k, bus.envelope, bus.gate, exp);
      end
    end
    step(1'b1, 8'sd98);
    n_chk++;
    if (bus.envelope !== 8'd196) begin
      n_err++;
      $display("FAIL release_step env=%0d want 196", bus.envelope);
    end
    step(1'b1, 8'sd97);
    n_chk++;
    if (bus.envelope !== 8'd194) begin
      n_err++;
      $display("FAIL release_clamp env=%0d want 194", bus.envelope);
    end
  endtask

  task automatic test_magnitude();
    do_reset();
    bus.ai    = 8'd255;
    bus.ri    = 8'd255;
    bus.th_on = 8'd255;
    step(1'b1, -8'sd128);
    n_chk++;
    if (bus.envelope !== 8'd254) begin
      n_err++;
      $display("FAIL mag_neg128 env=%0d want 254", bus.envelope);
    end
    step(1'b1, -8'sd1);
    n_chk++;
    if (bus.envelope !== 8'd2) begin
      n_err++;
      $display("FAIL mag_neg1 env=%0d want 2", bus.envelope);
    end
    step(1'b1, 8'sd127);
    n_chk++;
    if (bus.envelope !== 8'd254) begin
      n_err++;
      $display("FAIL mag_pos127 env=%0d want 254", bus.envelope);
    end
    bus.ri = 8'd0;
    step(1'b1, 8'sd0);
    n_chk++;
    if (bus.envelope !== 8'd254) begin
      n_err++;
      $display("FAIL ri0_freeze env=%0d want 254", bus.envelope);
    end
  endtask

  task automatic test_gate_hold();
    logic [2:0] exp_g;
    do_reset();
    gate_setup(8'd3);
    step(1'b1, 8'sd100);
    n_chk++;
    if (bus.envelope !== 8'd200 || bus.gate !== 1'b1
        || bus.onset !== 1'b1) begin
      n_err++;
      $display("FAIL gate_on env=%0d gate=%b onset=%b want 200 1 1",
               bus.envelope, bus.gate, bus.onset);
    end
    step(1'b0, 8'sd0);
    n_chk++;
    if (bus.onset !== 1'b0 || bus.gate !== 1'b1
        || bus.envelope !== 8'd200) begin
      n_err++;
      $display("FAIL gate_idlecyc env=%0d gate=%b onset=%b want 200 1 0",
               bus.envelope, bus.gate, bus.onset);
    end
    step(1'b1, 8'sd0);
    n_chk++;
    if (bus.envelope !== 8'd0 || bus.gate !== 1'b1
        || bus.onset !== 1'b0) begin
      n_err++;
      $display("FAIL gate_drop env=%0d gate=%b onset=%b want 0 1 0",
               bus.envelope, bus.gate, bus.onset);
    end
    exp_g = 3'b011;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'sd0);
      n_chk++;
      if (bus.gate !== exp_g[k] || bus.onset !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cnt[%0d] gate=%b onset=%b want %b 0",
                 k, bus.gate, bus.onset, exp_g[k]);
      end
    end
  endtask

  task automatic test_retrigger();
    do_reset();
    gate_setup(8'd3);
    step(1'b1, 8'sd100);
    step(1'b1, 8'sd0);
    step(1'b1, 8'sd100);
    n_chk++;
    if (bus.envelope !== 8'd200 || bus.gate !== 1'b1
        || bus.onset !== 1'b0) begin
      n_err++;
      $display("FAIL retrig env=%0d gate=%b onset=%b want 200 1 0",
               bus.envelope, bus.gate, bus.onset);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 8'sd100);
    n_chk++;
    if (bus.gate !== 1'b1) begin
      n_err++;
      $display("FAIL retrig_on gate=%b want 1", bus.gate);
    end
    do_reset();
    gate_setup(8'd0);
    step(1'b1, 8'sd100);
    step(1'b1, 8'sd0);
    n_chk++;
    if (bus.gate !== 1'b0 || bus.envelope !== 8'd0) begin
      n_err++;
      $display("FAIL hold0 gate=%b env=%0d want 0 0",
               bus.gate, bus.envelope);
    end
    step(1'b1, 8'sd100);
    n_chk++;
    if (bus.onset !== 1'b1 || bus.gate !== 1'b1) begin
      n_err++;
      $display("FAIL hold0_reon onset=%b gate=%b want 1 1",
               bus.onset, bus.gate);
    end
  endtask

  task automatic test_valid_gaps();
    logic [7:0] exp;
    do_reset();
    bus.ai     = 8'd16;
    bus.ri     = 8'd4;
    bus.th_on  = 8'd255;
    bus.th_off = 8'd0;
    bus.hold   = 8'd0;
    for (int k = 1; k <= 14; k++) begin
      step(1'b1, 8'sd100);
      exp = (k <= 12) ? 8'(16 * k) : 8'd200;
      n_chk++;
      if (bus.envelope !== exp) begin
        n_err++;
        $display("FAIL gap_v[%0d] env=%0d want %0d",
                 k, bus.envelope, exp);
      end
      step(1'b0, -8'sd128);
      n_chk++;
      if (bus.envelope !== exp) begin
        n_err++;
        $display("FAIL gap_nv[%0d] env=%0d want %0d",
                 k, bus.envelope, exp);
      end
    end
  endtask

  initial begin
    n_chk            = 0;
    n_err            = 0;
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample       = 8'sd0;
    bus.ai           = 8'd0;
    bus.ri           = 8'd0;
    bus.th_on        = 8'd255;
    bus.th_off       = 8'd0;
    bus.hold         = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_attack();
    test_magnitude();
    test_gate_hold();
    test_retrigger();
    test_valid_gaps();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
